// File: rtl/axi_s_s.sv
// rtl/axi_s_s.sv - AXI-Stream slave with first-word-fall-through FIFO and packet statistics
//
// Purpose: accepts DATA_W-bit beats with TLAST, buffers {tlast, tdata} in a
// DEPTH-entry FWFT FIFO and reports packet completion, length and count.
//
// Ports:
//   s_aclk, s_resetn        clock (rising edge), asynchronous active-low reset
//   s_tvalid/s_tdata/s_tlast/s_tready   stream input, ready = !full
//   rd_en                   consumer pop request (ignored while empty)
//   dout, dout_last, dout_valid   head-of-FIFO entry (combinational)
//   pkt_done                one-cycle pulse on an accepted TLAST beat
//   pkt_len                 beat count of last completed packet (saturates at 255)
//   pkt_cnt                 completed packet count modulo 256

module axi_s_s #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic              s_aclk,
  input  logic              s_resetn,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              s_tready,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_last,
  output logic              dout_valid,
  output logic              pkt_done,
  output logic [7:0]        pkt_len,
  output logic [7:0]        pkt_cnt
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  logic [DATA_W:0]   r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  state_t            r_state;
  logic [7:0]        r_beat_cnt;
  logic [7:0]        r_pkt_len;
  logic [7:0]        r_pkt_cnt;
  logic              r_pkt_done;

  logic              w_full;
  logic              w_acc;
  logic              w_pop;
  logic [DATA_W:0]   w_head;

  // Ready comes only from registered occupancy, so rd_en never reaches it
  // combinationally; a pop re-raises ready one edge later.
  assign w_full     = (r_count == FULL_CNT);
  assign s_tready   = s_resetn && !w_full;
  assign w_acc      = s_tvalid && s_tready;
  assign dout_valid = (r_count != '0);
  assign w_pop      = rd_en && dout_valid;

  assign w_head     = r_mem[r_rd_ptr];
  assign dout       = w_head[DATA_W-1:0];
  // Storage is not reset, so the stored last bit is masked while empty.
  assign dout_last  = dout_valid && w_head[DATA_W];

  assign pkt_done   = r_pkt_done;
  assign pkt_len    = r_pkt_len;
  assign pkt_cnt    = r_pkt_cnt;

  always_ff @(posedge s_aclk) begin
    if (w_acc) begin
      r_mem[r_wr_ptr] <= {s_tlast, s_tdata};
    end
  end

  always_ff @(posedge s_aclk or negedge s_resetn) begin
    if (!s_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_acc, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge s_aclk or negedge s_resetn) begin
    if (!s_resetn) begin
      r_state    <= IDLE;
      r_beat_cnt <= 8'd0;
      r_pkt_len  <= 8'd0;
      r_pkt_cnt  <= 8'd0;
      r_pkt_done <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      if (w_acc) begin
        if (s_tlast) begin
          // beat_cnt holds the beats before this one; add the TLAST beat itself.
          r_pkt_len  <= (r_beat_cnt == 8'hFF) ? 8'hFF : r_beat_cnt + 8'd1;
          r_pkt_cnt  <= r_pkt_cnt + 8'd1;
          r_pkt_done <= 1'b1;
          r_beat_cnt <= 8'd0;
        end else if (r_beat_cnt != 8'hFF) begin
          r_beat_cnt <= r_beat_cnt + 8'd1;
        end
        case (r_state)
          IDLE:    if (!s_tlast) r_state <= RECV;
          RECV:    if (s_tlast)  r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_s_s.sv
// tb/tb_axi_s_s.sv - directed self-checking bench for axi_s_s

module tb_axi_s_s;

  logic       s_aclk = 1'b0;
  logic       s_resetn = 1'b0;
  logic       s_tvalid = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       dout_last;
  logic       dout_valid;
  logic       pkt_done;
  logic [7:0] pkt_len;
  logic [7:0] pkt_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  axi_s_s #(.DATA_W(8), .DEPTH(8)) dut (
    .s_aclk     (s_aclk),
    .s_resetn   (s_resetn),
    .s_tvalid   (s_tvalid),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .s_tready   (s_tready),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .pkt_done   (pkt_done),
    .pkt_len    (pkt_len),
    .pkt_cnt    (pkt_cnt)
  );

  always #5 s_aclk = ~s_aclk;

  task automatic tick;
    @(posedge s_aclk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    tick;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic pop;
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
  endtask

  task automatic do_reset;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    rd_en    = 1'b0;
    s_resetn = 1'b0;
    tick;
    s_resetn = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    s_resetn = 1'b0;
    #3;
    n_tests++; if (s_tready !== 1'b0)   begin n_fail++; $display("FAIL rst_tready got=%0h exp=0", s_tready); end
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dout_valid got=%0h exp=0", dout_valid); end
    n_tests++; if (dout_last !== 1'b0)  begin n_fail++; $display("FAIL rst_dout_last got=%0h exp=0", dout_last); end
    n_tests++; if (pkt_done !== 1'b0)   begin n_fail++; $display("FAIL rst_pkt_done got=%0h exp=0", pkt_done); end
    n_tests++; if (pkt_len !== 8'h00)   begin n_fail++; $display("FAIL rst_pkt_len got=%0h exp=0", pkt_len); end
    n_tests++; if (pkt_cnt !== 8'h00)   begin n_fail++; $display("FAIL rst_pkt_cnt got=%0h exp=0", pkt_cnt); end
    tick;
    s_resetn = 1'b1;
    #1;
    n_tests++; if (s_tready !== 1'b1)   begin n_fail++; $display("FAIL rst_rel_tready got=%0h exp=1", s_tready); end
  endtask

  task automatic test_packet;
    logic [7:0] exp;
    do_reset;
    push(8'h11, 1'b0);
    n_tests++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL pkt_done_early got=%0h exp=0", pkt_done); end
    push(8'h22, 1'b0);
    push(8'h33, 1'b0);
    push(8'h44, 1'b1);
    n_tests++; if (pkt_done !== 1'b1) begin n_fail++; $display("FAIL pkt_done_pulse got=%0h exp=1", pkt_done); end
    n_tests++; if (pkt_len !== 8'd4)  begin n_fail++; $display("FAIL pkt_len4 got=%0d exp=4", pkt_len); end
    n_tests++; if (pkt_cnt !== 8'd1)  begin n_fail++; $display("FAIL pkt_cnt1 got=%0d exp=1", pkt_cnt); end
    n_tests++; if (dout !== 8'h11)    begin n_fail++; $display("FAIL pkt_head got=%0h exp=11", dout); end
    tick;
    n_tests++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL pkt_done_one_cycle got=%0h exp=0", pkt_done); end
    for (int i = 0; i < 4; i++) begin
      exp = 8'(8'h11 * (i + 1));
      n_tests++; if (dout_valid !== 1'b1 || dout !== exp) begin n_fail++; $display("FAIL pkt_pop%0d got=%0h/%0h exp=1/%0h", i, dout_valid, dout, exp); end
      n_tests++; if (dout_last !== (i == 3)) begin n_fail++; $display("FAIL pkt_last%0d got=%0h exp=%0h", i, dout_last, (i == 3)); end
      pop;
    end
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL pkt_empty got=%0h exp=0", dout_valid); end
  endtask

  task automatic test_full;
    logic [7:0] exp;
    do_reset;
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL full_ready%0d got=%0h exp=1", i, s_tready); end
      push(8'(i + 1), 1'b0);
    end
    n_tests++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL full_ready_low got=%0h exp=0", s_tready); end
    s_tvalid = 1'b1;
    s_tdata  = 8'h99;
    tick;
    tick;
    n_tests++; if (s_tready !== 1'b0 || dout !== 8'h01) begin n_fail++; $display("FAIL full_hold got=%0h/%0h exp=0/01", s_tready, dout); end
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    n_tests++; if (s_tready !== 1'b1 || dout !== 8'h02) begin n_fail++; $display("FAIL full_repop got=%0h/%0h exp=1/02", s_tready, dout); end
    tick;
    s_tvalid = 1'b0;
    n_tests++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL full_refill got=%0h exp=0", s_tready); end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 8'(i + 2) : 8'h99;
      n_tests++; if (dout_valid !== 1'b1 || dout !== exp) begin n_fail++; $display("FAIL full_order%0d got=%0h/%0h exp=1/%0h", i, dout_valid, dout, exp); end
      pop;
    end
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty got=%0h exp=0", dout_valid); end
  endtask

  task automatic test_single;
    int pulses = 0;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      push(8'hA5, 1'b1);
      if (pkt_done === 1'b1) pulses++;
      n_tests++; if (pkt_len !== 8'd1) begin n_fail++; $display("FAIL single_len%0d got=%0d exp=1", i, pkt_len); end
    end
    n_tests++; if (pulses != 3)         begin n_fail++; $display("FAIL single_pulses got=%0d exp=3", pulses); end
    n_tests++; if (pkt_cnt !== 8'd3)    begin n_fail++; $display("FAIL single_cnt got=%0d exp=3", pkt_cnt); end
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (dout !== 8'hA5 || dout_last !== 1'b1) begin n_fail++; $display("FAIL single_pop%0d got=%0h/%0h exp=a5/1", i, dout, dout_last); end
      pop;
    end
    push(8'h01, 1'b0);
    push(8'h02, 1'b1);
    n_tests++; if (pkt_len !== 8'd2 || pkt_cnt !== 8'd4) begin n_fail++; $display("FAIL single_after got=%0d/%0d exp=2/4", pkt_len, pkt_cnt); end
  endtask

  task automatic test_stream;
    do_reset;
    push(8'h10, 1'b0);
    for (int i = 0; i < 6; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(8'h20 + i);
      rd_en    = 1'b1;
      #1;
      n_tests++; if (s_tready !== 1'b1) begin n_fail++; $display("FAIL stream_ready%0d got=%0h exp=1", i, s_tready); end
      tick;
      n_tests++; if (dout_valid !== 1'b1 || dout !== 8'(8'h20 + i)) begin n_fail++; $display("FAIL stream_head%0d got=%0h/%0h exp=1/%0h", i, dout_valid, dout, 8'(8'h20 + i)); end
    end
    s_tvalid = 1'b0;
    tick;
    rd_en = 1'b0;
    n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL stream_occ1 got=%0h exp=0", dout_valid); end
  endtask

  task automatic test_empty_push_pop;
    do_reset;
    s_tvalid = 1'b1;
    s_tdata  = 8'h5A;
    rd_en    = 1'b1;
    tick;
    s_tvalid = 1'b0;
    rd_en    = 1'b0;
    n_tests++; if (dout_valid !== 1'b1 || dout !== 8'h5A) begin n_fail++; $display("FAIL empty_pushpop got=%0h/%0h exp=1/5a", dout_valid, dout); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    push(8'h31, 1'b0);
    push(8'h32, 1'b0);
    s_resetn = 1'b0;
    #1;
    n_tests++; if (s_tready !== 1'b0 || dout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst got=%0h/%0h exp=0/0", s_tready, dout_valid); end
    tick;
    s_resetn = 1'b1;
    #1;
    push(8'h61, 1'b0);
    push(8'h62, 1'b1);
    n_tests++; if (pkt_len !== 8'd2 || pkt_cnt !== 8'd1) begin n_fail++; $display("FAIL mid_newpkt got=%0d/%0d exp=2/1", pkt_len, pkt_cnt); end
    n_tests++; if (dout !== 8'h61) begin n_fail++; $display("FAIL mid_head got=%0h exp=61", dout); end
  endtask

  task automatic test_long;
    do_reset;
    rd_en = 1'b1;
    for (int i = 0; i < 299; i++) push(8'(i), 1'b0);
    push(8'hFE, 1'b1);
    rd_en = 1'b0;
    n_tests++; if (pkt_len !== 8'd255 || pkt_cnt !== 8'd1) begin n_fail++; $display("FAIL long_sat got=%0d/%0d exp=255/1", pkt_len, pkt_cnt); end
    n_tests++; if (dout !== 8'hFE || dout_last !== 1'b1) begin n_fail++; $display("FAIL long_tail got=%0h/%0h exp=fe/1", dout, dout_last); end
  endtask

  task automatic test_wrap;
    do_reset;
    rd_en = 1'b1;
    for (int i = 0; i < 257; i++) begin
      push(8'hA5, 1'b1);
      if (i == 255) begin
        n_tests++; if (pkt_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_zero got=%0d exp=0", pkt_cnt); end
      end
    end
    rd_en = 1'b0;
    n_tests++; if (pkt_cnt !== 8'd1 || pkt_len !== 8'd1) begin n_fail++; $display("FAIL wrap_one got=%0d/%0d exp=1/1", pkt_cnt, pkt_len); end
  endtask

  initial begin
    test_reset;
    test_packet;
    test_full;
    test_single;
    test_stream;
    test_empty_push_pop;
    test_reset_mid;
    test_long;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
